// File: rtl/shot_fire_controller_pkg.sv
// Shared state encoding and default frame counts for the shot fire controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FIRE,
      WAIT_LAUNCH,
      IN_FLIGHT,
      COOLDOWN
   } shot_state_t;

   localparam int DEF_COOLDOWN_FRAMES       = 8;
   localparam int DEF_RELOAD_FRAMES         = 60;
   localparam int DEF_LAUNCH_TIMEOUT_FRAMES = 2;
   localparam int DEF_AMMO_MAX              = 15;

endpackage

// File: rtl/shot_fire_controller_frame_tick_counter.sv
// Counts startOfFrame pulses while enabled; done pulses on the tick that reaches terminal.
// Latency: done is combinational with that tick; the count self-clears on the same edge.
// Backpressure: none; clear dominates enable, count saturates at all-ones.
module frame_tick_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             tick,
   input  logic [CNT_W-1:0] terminal,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;

   always_comb begin
      count_inc = (count == CNT_MAX) ? count : count + 1'b1;
      done      = enable & tick & ~clear & (count_inc >= terminal);
   end

   always_ff @(posedge clk) begin
      if (reset || clear || done) begin
         count <= '0;
      end else if (enable && tick) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/shot_fire_controller.sv
// Fire-key to one-cycle launch request, gated by one-in-flight, frame cooldown and reloading ammo.
// Latency: key rise sampled at edge n -> shotKeyIsPress high for the cycle after edge n.
// Backpressure: requests outside IDLE or with empty magazine are dropped; SHOT_AUTOFIRE_EN fires on key level.
module shot_fire_controller
   import shot_pkg::*;
#(
   parameter int COOLDOWN_FRAMES       = DEF_COOLDOWN_FRAMES,
   parameter int AMMO_MAX              = DEF_AMMO_MAX,
   parameter int AMMO_W                = 4,
   parameter int RELOAD_FRAMES         = DEF_RELOAD_FRAMES,
   parameter int LAUNCH_TIMEOUT_FRAMES = DEF_LAUNCH_TIMEOUT_FRAMES,
   parameter int CNT_W                 = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              startOfFrame,
   input  logic              fireKey,
   input  logic              missile_active,
   output logic              shotKeyIsPress,
   output logic [AMMO_W-1:0] ammo_count,
   output logic              ready
);

   localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

   shot_state_t state;
   logic        key_q;
   logic        key_rise;
   logic        fire_req;
   logic        fire;
   logic        ammo_full;
   logic        ammo_empty;
   logic        cd_done;
   logic        rl_done;
   logic        to_done;

   assign key_rise = fireKey & ~key_q;

`ifdef SHOT_AUTOFIRE_EN
   assign fire_req = fireKey | key_rise;
`else
   assign fire_req = key_rise;
`endif

   assign ammo_empty = (ammo_count == '0);
   assign ammo_full  = (ammo_count >= AMMO_FULL);
   assign fire       = (state == IDLE) & fire_req & ~ammo_empty;
   assign ready      = (state == IDLE) & ~ammo_empty;

   frame_tick_counter #(.CNT_W(CNT_W)) u_cooldown_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (state != COOLDOWN),
      .enable   (state == COOLDOWN),
      .tick     (startOfFrame),
      .terminal (CNT_W'(COOLDOWN_FRAMES)),
      .done     (cd_done)
   );

   // Reload runs in every state but is parked at zero while the magazine is full.
   frame_tick_counter #(.CNT_W(CNT_W)) u_reload_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (ammo_full),
      .enable   (~ammo_full),
      .tick     (startOfFrame),
      .terminal (CNT_W'(RELOAD_FRAMES)),
      .done     (rl_done)
   );

   frame_tick_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (state != WAIT_LAUNCH),
      .enable   (state == WAIT_LAUNCH),
      .tick     (startOfFrame),
      .terminal (CNT_W'(LAUNCH_TIMEOUT_FRAMES)),
      .done     (to_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         key_q          <= 1'b1;
         ammo_count     <= AMMO_FULL;
         shotKeyIsPress <= 1'b0;
      end else begin
         key_q          <= fireKey;
         shotKeyIsPress <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  state          <= FIRE;
                  shotKeyIsPress <= 1'b1;
               end
            end
            FIRE:        state <= WAIT_LAUNCH;
            WAIT_LAUNCH: begin
               if (missile_active) begin
                  state <= IN_FLIGHT;
               end else if (to_done) begin
                  state <= COOLDOWN;
               end
            end
            IN_FLIGHT: begin
               if (!missile_active) begin
                  state <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (COOLDOWN_FRAMES == 0 || cd_done) begin
                  state <= IDLE;
               end
            end
            default:     state <= IDLE;
         endcase
         // A reload tick landing on a fire edge cancels out.
         if (fire && !rl_done) begin
            ammo_count <= ammo_count - 1'b1;
         end else if (rl_done && !fire) begin
            ammo_count <= ammo_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shot_fire_controller.sv
// Scoreboard bench: stimulus pushes expected launch requests, a negedge monitor pops and checks them.
module tb_shot_fire_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       fireKey = 1'b0;
   logic       missile_active = 1'b0;
   logic       shotKeyIsPress;
   logic [3:0] ammo_count;
   logic       ready;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int cyc;
      int ammo;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_shot = 1'b0;

   int exp_after[17] = '{14, 13, 12, 11, 10, 9, 8, 7, 7, 6, 5, 4, 3, 2, 1, 1, 0};

   shot_fire_controller dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .fireKey        (fireKey),
      .missile_active (missile_active),
      .shotKeyIsPress (shotKeyIsPress),
      .ammo_count     (ammo_count),
      .ready          (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (shotKeyIsPress) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_shot: shotKeyIsPress=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            if (int'(ammo_count) != mon_e.ammo) begin
               fails++;
               $display("FAIL shot_ammo: ammo_count=%0d at cycle %0d, required %0d", ammo_count, cyc, mon_e.ammo);
            end
            if (mon_e.cyc >= 0) begin
               tests++;
               if (cyc != mon_e.cyc) begin
                  fails++;
                  $display("FAIL shot_latency: pulse at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
               end
            end
         end
      end else if (sb.size() != 0 && sb[0].cyc >= 0 && cyc >= sb[0].cyc) begin
         tests++;
         fails++;
         $display("FAIL missing_shot: shotKeyIsPress=0 at cycle %0d, required 1", cyc);
         mon_e = sb.pop_front();
      end
      if (shotKeyIsPress && prev_shot) begin
         tests++;
         fails++;
         $display("FAIL double_pulse: shotKeyIsPress high two cycles running at cycle %0d", cyc);
      end
      prev_shot <= shotKeyIsPress;
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int at_cyc, input int ammo);
      exp_t t;
      t.cyc  = at_cyc;
      t.ammo = ammo;
      sb.push_back(t);
   endtask

   // exp_ammo < 0 means the press must be ignored
   task automatic press(input int exp_ammo);
      @(negedge clk);
      fireKey = 1'b1;
      if (exp_ammo >= 0) push_exp(cyc + 1, exp_ammo);
      @(negedge clk);
      fireKey = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startOfFrame = 1'b1;
         @(negedge clk);
         startOfFrame = 1'b0;
         @(negedge clk);
      end
   endtask

   // Called in FIRE: missile seen in WAIT_LAUNCH, leaves at once, then full cooldown.
   task automatic fly();
      missile_active = 1'b1;
      @(negedge clk);
      @(negedge clk);
      missile_active = 1'b0;
      frames(8);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
`ifndef SHOT_AUTOFIRE_EN
      fireKey = 1'b1;
`endif
      @(negedge clk);
      check("rst_ammo", int'(ammo_count), 15);
      check("rst_ready", int'(ready), 1);
      check("rst_shot", int'(shotKeyIsPress), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      fireKey = 1'b0;
      @(negedge clk);

      // first shot, presses during flight and cooldown ignored
      press(14);
      check("fire_ready_low", int'(ready), 0);
      frames(1);
      @(negedge clk);
      missile_active = 1'b1;
      @(negedge clk);
      check("in_flight_ready", int'(ready), 0);
      frames(1);
      press(-1);
      frames(2);
      @(negedge clk);
      missile_active = 1'b0;
      frames(3);
      press(-1);
      frames(4);
      check("cooldown_ready_low", int'(ready), 0);
      frames(1);
      check("cooldown_done_ready", int'(ready), 1);
      check("ammo_after_first", int'(ammo_count), 14);

      // launch timeout: missile never appears
      press(13);
      frames(9);
      check("timeout_ready_low", int'(ready), 0);
      frames(1);
      check("timeout_ready", int'(ready), 1);
      check("timeout_ammo", int'(ammo_count), 13);

      // reset while a request is in flight drops it and refills
      press(12);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_reset_ammo", int'(ammo_count), 15);
      check("mid_reset_ready", int'(ready), 1);

      // drain the magazine; reload ticks land on frame pulses 60 and 120
      for (int k = 0; k < 17; k++) begin
         press(exp_after[k]);
         fly();
         check($sformatf("drain_ready_%0d", k), int'(ready), (exp_after[k] != 0) ? 1 : 0);
      end
      check("empty_ammo", int'(ammo_count), 0);
      frames(14);
      press(-1);
      check("empty_ready", int'(ready), 0);
      check("empty_press_ammo", int'(ammo_count), 0);
      frames(29);
      check("reload_pending", int'(ammo_count), 0);
      frames(1);
      check("reload_ammo", int'(ammo_count), 1);
      check("reload_ready", int'(ready), 1);
      frames(59);
      check("pre_same_edge_ammo", int'(ammo_count), 1);

      // fire and reload tick together, with startOfFrame in the same IDLE cycle
      @(negedge clk);
      fireKey = 1'b1;
      startOfFrame = 1'b1;
      push_exp(cyc + 1, 1);
      @(negedge clk);
      fireKey = 1'b0;
      startOfFrame = 1'b0;
      fly();
      check("same_edge_ammo", int'(ammo_count), 1);
      check("same_edge_ready", int'(ready), 1);

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`ifdef SHOT_AUTOFIRE_EN
      @(negedge clk);
      fireKey = 1'b1;
      push_exp(cyc + 1, 14);
      @(negedge clk);
      fly_hold_repeat();
`else
      // held key gives exactly one shot
      @(negedge clk);
      fireKey = 1'b1;
      push_exp(cyc + 1, 14);
      @(negedge clk);
      fly();
      frames(2);
      check("held_key_ready", int'(ready), 1);
      check("held_key_ammo", int'(ammo_count), 14);
      fireKey = 1'b0;
`endif

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

`ifdef SHOT_AUTOFIRE_EN
   task automatic fly_hold_repeat();
      missile_active = 1'b1;
      @(negedge clk);
      @(negedge clk);
      missile_active = 1'b0;
      frames(7);
      @(negedge clk);
      startOfFrame = 1'b1;
      push_exp(cyc + 2, 13);
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
      fireKey = 1'b0;
      fly();
      check("autofire_ammo", int'(ammo_count), 13);
   endtask
`endif

endmodule
